// File: rtl/AXI_package.sv
// Shared register-interface definitions for the Cicero command responder:
// command/status codes, register width and the responder FSM state type.
package AXI_package;

    localparam int REG_WIDTH = 32;

    localparam logic [REG_WIDTH-1:0] CMD_NOP                = 32'd0;
    localparam logic [REG_WIDTH-1:0] CMD_WRITE              = 32'd1;
    localparam logic [REG_WIDTH-1:0] CMD_READ               = 32'd2;
    localparam logic [REG_WIDTH-1:0] CMD_START              = 32'd3;
    localparam logic [REG_WIDTH-1:0] CMD_READ_ELAPSED_CLOCK = 32'd4;
    localparam logic [REG_WIDTH-1:0] CMD_READ_FIFO_COUNT    = 32'd5;
    localparam logic [REG_WIDTH-1:0] CMD_READ_CACHE_HITS    = 32'd6;
    localparam logic [REG_WIDTH-1:0] CMD_READ_CACHE_MISS    = 32'd7;

    localparam logic [REG_WIDTH-1:0] STATUS_IDLE     = 32'd0;
    localparam logic [REG_WIDTH-1:0] STATUS_RUNNING  = 32'd1;
    localparam logic [REG_WIDTH-1:0] STATUS_ACCEPTED = 32'd2;
    localparam logic [REG_WIDTH-1:0] STATUS_REJECTED = 32'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUNNING,
        ST_ACCEPTED,
        ST_REJECTED
    } responder_state_t;

    function automatic logic [REG_WIDTH-1:0] status_of(input responder_state_t s);
        case (s)
            ST_RUNNING:  status_of = STATUS_RUNNING;
            ST_ACCEPTED: status_of = STATUS_ACCEPTED;
            ST_REJECTED: status_of = STATUS_REJECTED;
            default:     status_of = STATUS_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/elapsed_clock_counter.sv
// Run-length counter: synchronous clear, count while enabled, sticks at all-ones.
module elapsed_clock_counter
    import AXI_package::*;
#(
    parameter int W = REG_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         enable,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/cicero_cmd_responder.sv
// Host command decoder for the Cicero engine: memory write/read passthrough,
// run control with accept/reject status, and stat/elapsed-time readback.
module cicero_cmd_responder
    import AXI_package::*;
#(
    parameter int BB_N       = 1,
    parameter int CC_ID_BITS = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [REG_WIDTH-1:0]              data_in_register,
    input  logic [REG_WIDTH-1:0]              address_register,
    input  logic [REG_WIDTH-1:0]              start_cc_pointer_register,
    input  logic [REG_WIDTH-1:0]              end_cc_pointer_register,
    input  logic [REG_WIDTH-1:0]              cmd_register,
    output logic [REG_WIDTH-1:0]              status_register,
    output logic [REG_WIDTH-1:0]              data_o_register,
    output logic [REG_WIDTH-1:0]              mem_addr,
    output logic [REG_WIDTH-1:0]              mem_wdata,
    output logic                              mem_we,
    input  logic [REG_WIDTH-1:0]              mem_rdata,
    output logic                              core_start,
    output logic [REG_WIDTH-1:0]              core_start_cc,
    output logic [REG_WIDTH-1:0]              core_end_cc,
    input  logic                              core_done,
    input  logic                              core_accept,
    input  logic [(2**CC_ID_BITS)*REG_WIDTH-1:0] fifo_max_count,
    input  logic [(2**CC_ID_BITS)*REG_WIDTH-1:0] cache_hits,
    input  logic [(2**CC_ID_BITS)*REG_WIDTH-1:0] cache_miss,
    output responder_state_t                  state_dbg
);

    localparam int N_SEL = 2**CC_ID_BITS;
    // An engine built with no basic blocks has nothing to start.
    localparam bit HAS_ENGINE = (BB_N > 0);

    responder_state_t       state_q, state_d;
    logic                   start_seen_q;
    logic                   read_pending_q;
    logic                   start_fire;
    logic [REG_WIDTH-1:0]   elapsed;
    logic [REG_WIDTH-1:0]   stat_value;
    logic                   load_stat;
    logic                   sel_ok;
    logic [CC_ID_BITS-1:0]  sel;

    wire running     = (state_q == ST_RUNNING);
    wire is_write    = (cmd_register == CMD_WRITE);
    wire is_read     = (cmd_register == CMD_READ);
    wire is_start    = (cmd_register == CMD_START);
    wire is_elapsed  = (cmd_register == CMD_READ_ELAPSED_CLOCK);
    wire is_fifo     = (cmd_register == CMD_READ_FIFO_COUNT);
    wire is_hits     = (cmd_register == CMD_READ_CACHE_HITS);
    wire is_miss     = (cmd_register == CMD_READ_CACHE_MISS);

    assign state_dbg = state_q;

    // Next state, memory strobes and start decision.
    always_comb begin
        state_d    = state_q;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        start_fire = 1'b0;

        if (!running) begin
            if (is_write) begin
                mem_we    = 1'b1;
                mem_addr  = address_register;
                mem_wdata = data_in_register;
            end else if (is_read) begin
                mem_addr = address_register;
            end
        end

        case (state_q)
            ST_RUNNING: begin
                if (core_done) begin
                    state_d = core_accept ? ST_ACCEPTED : ST_REJECTED;
                end
            end
            default: begin
                // A START held across a whole run must not relaunch it.
                if (is_start && !start_seen_q && HAS_ENGINE) begin
                    start_fire = 1'b1;
                    state_d    = ST_RUNNING;
                end
            end
        endcase
    end

    // Stat readback mux; out-of-range selectors read as zero.
    always_comb begin
        sel_ok     = (data_in_register < REG_WIDTH'(N_SEL));
        sel        = data_in_register[CC_ID_BITS-1:0];
        stat_value = '0;
        load_stat  = is_elapsed | is_fifo | is_hits | is_miss;
        if (is_elapsed) begin
            stat_value = elapsed;
        end else if (sel_ok) begin
            if (is_fifo) stat_value = fifo_max_count[sel*REG_WIDTH +: REG_WIDTH];
            if (is_hits) stat_value = cache_hits[sel*REG_WIDTH +: REG_WIDTH];
            if (is_miss) stat_value = cache_miss[sel*REG_WIDTH +: REG_WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            status_register <= STATUS_IDLE;
            data_o_register <= '0;
            core_start      <= 1'b0;
            core_start_cc   <= '0;
            core_end_cc     <= '0;
            start_seen_q    <= 1'b0;
            read_pending_q  <= 1'b0;
        end else begin
            state_q         <= state_d;
            status_register <= status_of(state_d);
            core_start      <= start_fire;
            start_seen_q    <= is_start;
            read_pending_q  <= is_read && !running;
            if (start_fire) begin
                core_start_cc <= start_cc_pointer_register;
                core_end_cc   <= end_cc_pointer_register;
            end
            // Memory returns data one cycle after the address, so a pending
            // read lands here on the following edge.
            if (read_pending_q) begin
                data_o_register <= mem_rdata;
            end else if (load_stat) begin
                data_o_register <= stat_value;
            end
        end
    end

    elapsed_clock_counter #(.W(REG_WIDTH)) u_elapsed (
        .clk    (clk),
        .rst    (rst),
        .clear  (start_fire),
        .enable (running),
        .count  (elapsed)
    );

endmodule

// File: tb/tb_cicero_cmd_responder.sv
// Directed bench for cicero_cmd_responder with a one-cycle-latency memory model.
module tb_cicero_cmd_responder;
  import AXI_package::*;

  localparam int CC_ID_BITS = 2;
  localparam int N_SEL = 2**CC_ID_BITS;

  logic clk = 1'b0;
  logic rst;
  logic [31:0] data_in_register, address_register;
  logic [31:0] start_cc_pointer_register, end_cc_pointer_register, cmd_register;
  logic [31:0] status_register, data_o_register;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic mem_we;
  logic core_start, core_done, core_accept;
  logic [31:0] core_start_cc, core_end_cc;
  logic [N_SEL*32-1:0] fifo_max_count, cache_hits, cache_miss;
  responder_state_t state_dbg;

  int checks = 0;
  int failures = 0;
  int start_pulses = 0;
  int pulses_before;

  logic [31:0] mem [0:255];

  cicero_cmd_responder #(.BB_N(1), .CC_ID_BITS(CC_ID_BITS)) dut (
    .clk(clk), .rst(rst),
    .data_in_register(data_in_register), .address_register(address_register),
    .start_cc_pointer_register(start_cc_pointer_register),
    .end_cc_pointer_register(end_cc_pointer_register),
    .cmd_register(cmd_register), .status_register(status_register),
    .data_o_register(data_o_register), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_rdata(mem_rdata), .core_start(core_start),
    .core_start_cc(core_start_cc), .core_end_cc(core_end_cc),
    .core_done(core_done), .core_accept(core_accept),
    .fifo_max_count(fifo_max_count), .cache_hits(cache_hits), .cache_miss(cache_miss),
    .state_dbg(state_dbg)
  );

  // clock / memory model / pulse monitor
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
    mem_rdata <= mem[mem_addr[7:0]];
  end

  always @(negedge clk) begin
    if (core_start === 1'b1) start_pulses++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cmd_register = CMD_NOP;
    data_in_register = '0;
    address_register = '0;
    start_cc_pointer_register = '0;
    end_cc_pointer_register = '0;
    core_done = 1'b0;
    core_accept = 1'b0;
    fifo_max_count = '0;
    cache_hits = '0;
    cache_miss = '0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    checks++; if (status_register !== STATUS_IDLE) begin failures++; $display("FAIL reset_status got %h expected %h", status_register, STATUS_IDLE); end
    checks++; if (data_o_register !== 32'h0) begin failures++; $display("FAIL reset_data_o got %h expected 0", data_o_register); end
    checks++; if (core_start !== 1'b0) begin failures++; $display("FAIL reset_core_start got %b expected 0", core_start); end
    checks++; if (core_start_cc !== 32'h0 || core_end_cc !== 32'h0) begin failures++; $display("FAIL reset_pointers got %h/%h expected 0/0", core_start_cc, core_end_cc); end
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem_we got %b expected 0", mem_we); end
  endtask

  task automatic test_write();
    cmd_register = CMD_WRITE;
    address_register = 32'h10;
    data_in_register = 32'hDEADBEEF;
    #1;
    checks++; if (mem_we !== 1'b1) begin failures++; $display("FAIL write_we got %b expected 1", mem_we); end
    checks++; if (mem_addr !== 32'h10) begin failures++; $display("FAIL write_addr got %h expected 10", mem_addr); end
    checks++; if (mem_wdata !== 32'hDEADBEEF) begin failures++; $display("FAIL write_data got %h expected deadbeef", mem_wdata); end
    tick();
    address_register = 32'h11;
    data_in_register = 32'h12345678;
    #1;
    checks++; if (mem_we !== 1'b1 || mem_addr !== 32'h11 || mem_wdata !== 32'h12345678) begin failures++; $display("FAIL write_stream got we=%b addr=%h data=%h expected 1/11/12345678", mem_we, mem_addr, mem_wdata); end
    tick();
    cmd_register = CMD_NOP;
    #1;
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL write_nop_we got %b expected 0", mem_we); end
  endtask

  task automatic test_read();
    cmd_register = CMD_READ;
    address_register = 32'h10;
    #1;
    checks++; if (mem_addr !== 32'h10 || mem_we !== 1'b0) begin failures++; $display("FAIL read_addr got addr=%h we=%b expected 10/0", mem_addr, mem_we); end
    tick();
    cmd_register = CMD_NOP;
    tick();
    checks++; if (data_o_register !== 32'hDEADBEEF) begin failures++; $display("FAIL read_data got %h expected deadbeef", data_o_register); end
    tick();
    tick();
    checks++; if (data_o_register !== 32'hDEADBEEF) begin failures++; $display("FAIL read_hold got %h expected deadbeef", data_o_register); end
    // back-to-back reads of two addresses
    cmd_register = CMD_READ;
    address_register = 32'h11;
    tick();
    address_register = 32'h10;
    tick();
    cmd_register = CMD_NOP;
    checks++; if (data_o_register !== 32'h12345678) begin failures++; $display("FAIL read_b2b_first got %h expected 12345678", data_o_register); end
    tick();
    checks++; if (data_o_register !== 32'hDEADBEEF) begin failures++; $display("FAIL read_b2b_second got %h expected deadbeef", data_o_register); end
  endtask

  task automatic test_accepted_run();
    pulses_before = start_pulses;
    start_cc_pointer_register = 32'h40;
    end_cc_pointer_register = 32'h4F;
    cmd_register = CMD_START;
    tick();
    checks++; if (status_register !== STATUS_RUNNING) begin failures++; $display("FAIL run_status got %h expected %h", status_register, STATUS_RUNNING); end
    checks++; if (core_start !== 1'b1) begin failures++; $display("FAIL run_pulse got %b expected 1", core_start); end
    checks++; if (core_start_cc !== 32'h40 || core_end_cc !== 32'h4F) begin failures++; $display("FAIL run_pointers got %h/%h expected 40/4f", core_start_cc, core_end_cc); end
    tick();
    checks++; if (core_start !== 1'b0) begin failures++; $display("FAIL run_pulse_width got %b expected 0", core_start); end
    tick();
    cmd_register = CMD_NOP;
    repeat (97) tick();
    core_done = 1'b1;
    core_accept = 1'b1;
    tick();
    core_done = 1'b0;
    core_accept = 1'b0;
    checks++; if (status_register !== STATUS_ACCEPTED) begin failures++; $display("FAIL run_accepted got %h expected %h", status_register, STATUS_ACCEPTED); end
    checks++; if (start_pulses - pulses_before !== 1) begin failures++; $display("FAIL run_single_pulse got %0d expected 1", start_pulses - pulses_before); end
    cmd_register = CMD_READ_ELAPSED_CLOCK;
    tick();
    cmd_register = CMD_NOP;
    checks++; if (data_o_register !== 32'd100) begin failures++; $display("FAIL run_elapsed got %0d expected 100", data_o_register); end
    tick();
    tick();
    checks++; if (status_register !== STATUS_ACCEPTED) begin failures++; $display("FAIL run_accepted_hold got %h expected %h", status_register, STATUS_ACCEPTED); end
  endtask

  task automatic test_running_cmds();
    start_cc_pointer_register = 32'h50;
    end_cc_pointer_register = 32'h60;
    cmd_register = CMD_START;
    tick();
    pulses_before = start_pulses;
    checks++; if (status_register !== STATUS_RUNNING) begin failures++; $display("FAIL busy_status got %h expected %h", status_register, STATUS_RUNNING); end
    cmd_register = CMD_WRITE;
    address_register = 32'h20;
    data_in_register = 32'hCAFEF00D;
    #1;
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL busy_write_we got %b expected 0", mem_we); end
    tick();
    cmd_register = CMD_READ;
    address_register = 32'h10;
    tick();
    cmd_register = CMD_NOP;
    tick();
    tick();
    checks++; if (data_o_register !== 32'd100) begin failures++; $display("FAIL busy_read_ignored got %h expected 64", data_o_register); end
    start_cc_pointer_register = 32'h70;
    end_cc_pointer_register = 32'h7F;
    cmd_register = CMD_START;
    tick();
    tick();
    cmd_register = CMD_NOP;
    tick();
    checks++; if (start_pulses - pulses_before !== 1 || core_start_cc !== 32'h50) begin failures++; $display("FAIL busy_start_ignored got pulses=%0d cc=%h expected 1/50", start_pulses - pulses_before, core_start_cc); end
    core_done = 1'b1;
    core_accept = 1'b0;
    tick();
    core_done = 1'b0;
    checks++; if (status_register !== STATUS_REJECTED) begin failures++; $display("FAIL busy_rejected got %h expected %h", status_register, STATUS_REJECTED); end
    core_done = 1'b1;
    core_accept = 1'b1;
    tick();
    core_done = 1'b0;
    core_accept = 1'b0;
    tick();
    checks++; if (status_register !== STATUS_REJECTED) begin failures++; $display("FAIL busy_done_ignored got %h expected %h", status_register, STATUS_REJECTED); end
  endtask

  task automatic test_stats();
    fifo_max_count = {32'd33, 32'd7, 32'd22, 32'd11};
    cache_hits = {32'd44, 32'd66, 32'd5, 32'd88};
    cache_miss = {32'd99, 32'd77, 32'd3, 32'd55};
    cmd_register = CMD_READ_FIFO_COUNT;
    data_in_register = 32'd2;
    tick();
    checks++; if (data_o_register !== 32'd7) begin failures++; $display("FAIL stat_fifo_sel2 got %0d expected 7", data_o_register); end
    data_in_register = 32'd9;
    tick();
    checks++; if (data_o_register !== 32'd0) begin failures++; $display("FAIL stat_fifo_sel9 got %0d expected 0", data_o_register); end
    data_in_register = 32'd3;
    tick();
    checks++; if (data_o_register !== 32'd33) begin failures++; $display("FAIL stat_fifo_sel3 got %0d expected 33", data_o_register); end
    cmd_register = CMD_READ_CACHE_HITS;
    data_in_register = 32'd1;
    tick();
    checks++; if (data_o_register !== 32'd5) begin failures++; $display("FAIL stat_hits_sel1 got %0d expected 5", data_o_register); end
    cmd_register = CMD_READ_CACHE_MISS;
    tick();
    checks++; if (data_o_register !== 32'd3) begin failures++; $display("FAIL stat_miss_sel1 got %0d expected 3", data_o_register); end
    cmd_register = 32'hABCD;
    tick();
    checks++; if (data_o_register !== 32'd3 || mem_we !== 1'b0) begin failures++; $display("FAIL stat_unknown_cmd got data=%0d we=%b expected 3/0", data_o_register, mem_we); end
    cmd_register = CMD_NOP;
    tick();
  endtask

  task automatic test_reset_mid_run();
    start_cc_pointer_register = 32'h80;
    end_cc_pointer_register = 32'h8F;
    cmd_register = CMD_START;
    tick();
    cmd_register = CMD_NOP;
    repeat (9) tick();
    pulses_before = start_pulses;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (status_register !== STATUS_IDLE) begin failures++; $display("FAIL abort_status got %h expected %h", status_register, STATUS_IDLE); end
    checks++; if (core_start !== 1'b0 || core_start_cc !== 32'h0) begin failures++; $display("FAIL abort_outputs got start=%b cc=%h expected 0/0", core_start, core_start_cc); end
    cmd_register = CMD_READ_ELAPSED_CLOCK;
    tick();
    cmd_register = CMD_NOP;
    checks++; if (data_o_register !== 32'd0) begin failures++; $display("FAIL abort_elapsed got %0d expected 0", data_o_register); end
    core_done = 1'b1;
    core_accept = 1'b1;
    tick();
    core_done = 1'b0;
    core_accept = 1'b0;
    tick();
    checks++; if (status_register !== STATUS_IDLE) begin failures++; $display("FAIL abort_done_ignored got %h expected %h", status_register, STATUS_IDLE); end
    checks++; if (start_pulses !== pulses_before) begin failures++; $display("FAIL abort_no_pulse got %0d expected %0d", start_pulses, pulses_before); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_accepted_run();
    test_running_cmds();
    test_stats();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
